atm_controller: RTL and testbench
=================================

// Module: atm_controller
// PURPOSE
//   Responder side of the ATM stimulus interface. Accepts card-insert, PIN digits,
//   transaction type and amount. Verifies the 4-digit PIN, counts failed attempts,
//   blocks the card after 3 failures, then performs a deposit or withdrawal against
//   a stored balance and reports the result on single-cycle status pulses.
// PARAMETERS
//   PIN           16'h4756   expected PIN, 4 BCD nibbles, first-entered digit in [15:12]
//   BALANCE_INIT  64'd50000  balance loaded on reset
//   MAX_TRIES     2'd3       failed PIN attempts that cause bloqueo
// PORTS
//   clk                   in   1   rising-edge clock
//   rst                   in   1   asynchronous reset, active-low (0 = reset)
//   tarjeta_recibida      in   1   card inserted, sampled high for >=1 cycle
//   tipo_trans            in   1   0 = deposit, 1 = withdrawal; sampled with monto_stb
//   digito                in   4   PIN digit, valid when digito_stb=1
//   digito_stb            in   1   one-cycle strobe: digito valid
//   monto                 in   32  amount, valid when monto_stb=1
//   monto_stb             in   1   one-cycle strobe: monto/tipo_trans valid
//   balance_actualizado   out  1   pulse: balance changed
//   entregar_dinero       out  1   pulse: dispense cash (withdrawal only)
//   pin_incorrecto        out  1   pulse: PIN check failed
//   advertencia           out  1   level: one attempt remains
//   bloqueo               out  1   level: card blocked
//   fondos_insuficientes  out  1   pulse: withdrawal rejected
//   balance               out  64  current balance
// BEHAVIOUR
//   - All outputs registered. rst=0: state IDLE, digit count 0, PIN shift reg 0,
//     attempts 0, balance=BALANCE_INIT, all 1-bit outputs 0. Async assert, sync use.
//   - Pulses are high exactly one cycle, in the cycle after the edge that decided them.
//   - FSM states: IDLE, PIN_ENTRY, PIN_CHECK, WAIT_TRANS, BLOCKED.
//   - IDLE: tarjeta_recibida=1 -> PIN_ENTRY; clear digit count and shift reg.
//   - PIN_ENTRY: each digito_stb shifts reg <= {reg[11:0],digito}, count+1; on the
//     4th strobe -> PIN_CHECK. Strobes with digito>9 still accepted (compare fails).
//   - PIN_CHECK (1 cycle): match -> WAIT_TRANS, attempts<=0, advertencia<=0.
//     Mismatch -> attempts+1, pin_incorrecto pulse; new attempts==MAX_TRIES-1 sets
//     advertencia; ==MAX_TRIES sets bloqueo, clears advertencia, -> BLOCKED;
//     else -> PIN_ENTRY with count/reg cleared.
//   - WAIT_TRANS on monto_stb, then -> IDLE:
//       deposit: balance += zero-extended monto, saturating at 2^64-1;
//                balance_actualizado pulse.
//       withdrawal, monto<=balance: balance -= monto; balance_actualizado and
//                entregar_dinero pulse in the same cycle.
//       withdrawal, monto>balance: balance unchanged; fondos_insuficientes pulse.
//     monto=0 is legal: balance unchanged, pulses still issued as above.
//   - BLOCKED: absorbing; bloqueo held 1; every input ignored until rst=0.
//   - Attempts persist across card sessions; cleared only by correct PIN or reset.
//   - Ignored inputs: tarjeta_recibida outside IDLE, digito_stb outside PIN_ENTRY,
//     monto_stb outside WAIT_TRANS. digito_stb with monto_stb in WAIT_TRANS:
//     only monto_stb acts.
//   - Reset mid-operation: partial PIN, pending transaction and attempts discarded.
//   - Latency: last PIN digit edge -> PIN result 2 cycles; monto_stb edge -> pulse 1 cycle.
// TESTING
//   1 reset; card; digits 4,7,5,6; tipo=0, monto=2000 -> balance_actualizado 1 cycle,
//     balance=52000, back to IDLE, no other pulse.
//   2 correct PIN; tipo=1, monto=10000 -> balance_actualizado+entregar_dinero same
//     cycle, balance=40000.
//   3 correct PIN; tipo=1, monto=60000 (balance 50000) -> fondos_insuficientes only,
//     balance stays 50000.
//   4 PIN 1,1,1,1 twice -> two pin_incorrecto pulses, advertencia=1 after second;
//     then 4,7,5,6 -> WAIT_TRANS, advertencia=0.
//   5 three wrong PINs -> bloqueo=1, advertencia=0; later card and strobes ignored;
//     rst=0 -> bloqueo=0, balance=50000.
//   6 rst=0 after 2 digits entered -> IDLE, outputs 0; new card + 4,7,5,6 accepted
//     on the first try.

Source files
------------

// File: rtl/atm_controller.sv
// ATM responder: card/PIN session control, failed-attempt tracking with card
// blocking, and deposit/withdrawal against a stored 64-bit balance.
module atm_controller #(
  parameter logic [15:0] PIN          = 16'h4756,
  parameter logic [63:0] BALANCE_INIT = 64'd50000,
  parameter logic [1:0]  MAX_TRIES    = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tarjeta_recibida,
  input  logic        tipo_trans,
  input  logic [3:0]  digito,
  input  logic        digito_stb,
  input  logic [31:0] monto,
  input  logic        monto_stb,
  output logic        balance_actualizado,
  output logic        entregar_dinero,
  output logic        pin_incorrecto,
  output logic        advertencia,
  output logic        bloqueo,
  output logic        fondos_insuficientes,
  output logic [63:0] balance
);

  typedef enum logic [2:0] {
    IDLE,
    PIN_ENTRY,
    PIN_CHECK,
    WAIT_TRANS,
    BLOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pin_q, pin_d;
  logic [1:0]  tries_q, tries_d;
  logic [63:0] balance_q, balance_d;
  logic        bal_upd_q, bal_upd_d;
  logic        entregar_q, entregar_d;
  logic        pin_inc_q, pin_inc_d;
  logic        adv_q, adv_d;
  logic        bloq_q, bloq_d;
  logic        fondos_q, fondos_d;

  logic [1:0]  tries_inc;
  logic [63:0] monto_ext;

  // Deposit never wraps: a carry out of bit 63 pins the balance at all-ones.
  function automatic logic [63:0] sat_add(input logic [63:0] bal,
                                          input logic [63:0] amt);
    logic [64:0] sum;
    sum = {1'b0, bal} + {1'b0, amt};
    return sum[64] ? {64{1'b1}} : sum[63:0];
  endfunction

  assign tries_inc = tries_q + 2'd1;
  assign monto_ext = {32'd0, monto};

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pin_d      = pin_q;
    tries_d    = tries_q;
    balance_d  = balance_q;
    bal_upd_d  = 1'b0;
    entregar_d = 1'b0;
    pin_inc_d  = 1'b0;
    fondos_d   = 1'b0;
    adv_d      = adv_q;
    bloq_d     = bloq_q;

    case (state_q)
      IDLE: begin
        if (tarjeta_recibida) begin
          state_d = PIN_ENTRY;
          cnt_d   = 3'd0;
          pin_d   = 16'd0;
        end
      end

      PIN_ENTRY: begin
        // Non-decimal digits are shifted in as-is; they simply fail the compare.
        if (digito_stb) begin
          pin_d = {pin_q[11:0], digito};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            state_d = PIN_CHECK;
          end
        end
      end

      PIN_CHECK: begin
        if (pin_q == PIN) begin
          state_d = WAIT_TRANS;
          tries_d = 2'd0;
          adv_d   = 1'b0;
        end else begin
          tries_d   = tries_inc;
          pin_inc_d = 1'b1;
          if (tries_inc == MAX_TRIES) begin
            bloq_d  = 1'b1;
            adv_d   = 1'b0;
            state_d = BLOCKED;
          end else begin
            if (tries_inc == MAX_TRIES - 2'd1) begin
              adv_d = 1'b1;
            end
            state_d = PIN_ENTRY;
            cnt_d   = 3'd0;
            pin_d   = 16'd0;
          end
        end
      end

      WAIT_TRANS: begin
        if (monto_stb) begin
          state_d = IDLE;
          if (!tipo_trans) begin
            balance_d = sat_add(balance_q, monto_ext);
            bal_upd_d = 1'b1;
          end else if (monto_ext <= balance_q) begin
            balance_d  = balance_q - monto_ext;
            bal_upd_d  = 1'b1;
            entregar_d = 1'b1;
          end else begin
            fondos_d = 1'b1;
          end
        end
      end

      BLOCKED: begin
        bloq_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any session in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      pin_q      <= 16'd0;
      tries_q    <= 2'd0;
      balance_q  <= BALANCE_INIT;
      bal_upd_q  <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
      fondos_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pin_q      <= pin_d;
      tries_q    <= tries_d;
      balance_q  <= balance_d;
      bal_upd_q  <= bal_upd_d;
      entregar_q <= entregar_d;
      pin_inc_q  <= pin_inc_d;
      adv_q      <= adv_d;
      bloq_q     <= bloq_d;
      fondos_q   <= fondos_d;
    end
  end

  assign balance_actualizado  = bal_upd_q;
  assign entregar_dinero      = entregar_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = bloq_q;
  assign fondos_insuficientes = fondos_q;
  assign balance              = balance_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller: deposits, withdrawals, PIN failures,
// blocking and mid-session reset, with hand-computed expectations.
module tb_atm_controller;

  logic        clk;
  logic        rst;
  logic        tarjeta_recibida;
  logic        tipo_trans;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        fondos_insuficientes;
  logic [63:0] balance;

  int checks   = 0;
  int failures = 0;

  atm_controller dut (
    .clk                  (clk),
    .rst                  (rst),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .digito               (digito),
    .digito_stb           (digito_stb),
    .monto                (monto),
    .monto_stb            (monto_stb),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .pin_incorrecto       (pin_incorrecto),
    .advertencia          (advertencia),
    .bloqueo              (bloqueo),
    .fondos_insuficientes (fondos_insuficientes),
    .balance              (balance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Packs the six status bits {upd,entregar,pin_inc,adv,bloq,fondos}.
  function automatic logic [63:0] flags();
    return {58'd0, balance_actualizado, entregar_dinero, pin_incorrecto,
            advertencia, bloqueo, fondos_insuficientes};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic insert_card();
    @(negedge clk);
    tarjeta_recibida = 1'b1;
    @(negedge clk);
    tarjeta_recibida = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    @(negedge clk);
    digito     = d;
    digito_stb = 1'b1;
  endtask

  // Returns at the negedge where the PIN-check result is visible.
  task automatic send_pin(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    send_digit(a);
    send_digit(b);
    send_digit(c);
    send_digit(d);
    @(negedge clk);
    digito_stb = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge where the transaction pulse is visible.
  task automatic send_monto(input logic t, input logic [31:0] m);
    @(negedge clk);
    tipo_trans = t;
    monto      = m;
    monto_stb  = 1'b1;
    @(negedge clk);
    monto_stb  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    tarjeta_recibida = 1'b0;
    tipo_trans = 1'b0;
    digito = 4'd0;
    digito_stb = 1'b0;
    monto = 32'd0;
    monto_stb = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_balance", balance, 64'd50000);
    check("reset_flags", flags(), 64'd0);
    rst = 1'b1;

    // 1: deposit 2000
    insert_card();
    send_pin(4'd4, 4'd7, 4'd5, 4'd6);
    check("t1_pin_ok", flags(), 64'd0);
    send_monto(1'b0, 32'd2000);
    check("t1_flags", flags(), 64'b100000);
    check("t1_balance", balance, 64'd52000);
    @(negedge clk);
    check("t1_pulse_one_cycle", flags(), 64'd0);
    // Back in IDLE: a stray monto strobe must do nothing.
    send_monto(1'b0, 32'd500);
    check("t1_idle_ignores_monto", flags(), 64'd0);
    check("t1_idle_balance", balance, 64'd52000);

    // 2: withdrawal 10000 from 50000
    do_reset();
    insert_card();
    send_pin(4'd4, 4'd7, 4'd5, 4'd6);
    send_monto(1'b1, 32'd10000);
    check("t2_flags", flags(), 64'b110000);
    check("t2_balance", balance, 64'd40000);
    @(negedge clk);
    check("t2_pulse_one_cycle", flags(), 64'd0);

    // 3: withdrawal exceeding balance
    do_reset();
    insert_card();
    send_pin(4'd4, 4'd7, 4'd5, 4'd6);
    send_monto(1'b1, 32'd60000);
    check("t3_flags", flags(), 64'b000001);
    check("t3_balance", balance, 64'd50000);
    // Exact-balance withdrawal is allowed and drains to zero.
    insert_card();
    send_pin(4'd4, 4'd7, 4'd5, 4'd6);
    send_monto(1'b1, 32'd50000);
    check("t3_exact_flags", flags(), 64'b110000);
    check("t3_exact_balance", balance, 64'd0);

    // 4: two wrong PINs then correct
    do_reset();
    insert_card();
    send_pin(4'd1, 4'd1, 4'd1, 4'd1);
    check("t4_wrong1", flags(), 64'b001000);
    @(negedge clk);
    check("t4_wrong1_clear", flags(), 64'd0);
    send_pin(4'd1, 4'd1, 4'd1, 4'd1);
    check("t4_wrong2", flags(), 64'b001100);
    send_pin(4'd4, 4'd7, 4'd5, 4'd6);
    check("t4_correct", flags(), 64'd0);
    send_monto(1'b0, 32'd0);
    check("t4_zero_deposit_flags", flags(), 64'b100000);
    check("t4_zero_deposit_balance", balance, 64'd50000);

    // 5: three wrong PINs block the card (one digit non-decimal)
    do_reset();
    insert_card();
    send_pin(4'd1, 4'd2, 4'd3, 4'd4);
    send_pin(4'd4, 4'd7, 4'd5, 4'd7);
    check("t5_wrong2", flags(), 64'b001100);
    send_pin(4'd4, 4'd7, 4'd5, 4'hF);
    check("t5_blocked", flags(), 64'b001010);
    insert_card();
    send_pin(4'd4, 4'd7, 4'd5, 4'd6);
    send_monto(1'b0, 32'd1000);
    check("t5_ignored_flags", flags(), 64'b000010);
    check("t5_ignored_balance", balance, 64'd50000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_async_reset_flags", flags(), 64'd0);
    check("t5_async_reset_balance", balance, 64'd50000);
    @(negedge clk);
    rst = 1'b1;

    // 6: reset after two digits, then a clean first-try session
    insert_card();
    send_digit(4'd4);
    send_digit(4'd7);
    @(negedge clk);
    digito_stb = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_reset_flags", flags(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    insert_card();
    send_pin(4'd4, 4'd7, 4'd5, 4'd6);
    check("t6_pin_ok", flags(), 64'd0);
    send_monto(1'b0, 32'd1);
    check("t6_deposit_flags", flags(), 64'b100000);
    check("t6_deposit_balance", balance, 64'd50001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
